// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: FSM states and sizing helpers shared by the DDR3 ROM loader.
package jtframe_dwnld_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_FILL, ST_SER, ST_WAIT, ST_FIN} state_t;
   function automatic int byte_step(input int ow);
      return ow / 8;
   endfunction
   function automatic logic [7:0] min_burst(input logic [31:0] left, input int unsigned burst);
      return left < burst ? left[7:0] : burst[7:0];
   endfunction
endpackage

// File: rtl/jtframe_ddr_romload_buf.sv
// jtframe_ddr_romload_buf: one DDR3 burst of 64-bit words, read back as OW-bit
// little-endian slices.
module jtframe_ddr_romload_buf #(
   parameter int OW    = 8,
   parameter int BURST = 32
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          clr,
   input  logic          we,
   input  logic          adv,
   input  logic [63:0]   din,
   output logic [7:0]    wcnt,
   output logic [7:0]    rword,
   output logic          last_slice,
   output logic [OW-1:0] slice
);
   localparam int SPW = 64 / OW;
   localparam int SW  = $clog2(SPW);
   localparam int IW  = BURST > 1 ? $clog2(BURST) : 1;
   logic [63:0]   mem [BURST];
   logic [63:0]   word;
   logic [SW-1:0] rs;
   always_ff @(posedge clk)
      if (we) mem[wcnt[IW-1:0]] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wcnt  <= '0;
         rword <= '0;
         rs    <= '0;
      end else if (clr) begin
         wcnt  <= '0;
         rword <= '0;
         rs    <= '0;
      end else begin
         if (we) wcnt <= wcnt + 8'd1;
         if (adv) begin
            rs <= rs + 1'b1;
            if (last_slice) rword <= rword + 8'd1;
         end
      end
   assign last_slice = rs == SW'(SPW - 1);
   assign word       = mem[rword[IW-1:0]];
   assign slice      = word[32'(rs) * OW +: OW];
endmodule

// File: rtl/jtframe_ddr_romload.sv
// jtframe_ddr_romload: streams len bytes from DDR3 into the core programmer as OW-bit ioctl writes.
// Define JTFRAME_DWNLD_CKSUM_EN to add cksum, the 16-bit sum of all bytes written.
module jtframe_ddr_romload
   import jtframe_dwnld_pkg::*;
#(
   parameter int OW     = 8,
   parameter int BURST  = 32,
   parameter int AW     = 27,
   parameter int DDR_AW = 29
)(
   input  logic              rst,
   input  logic              clk,
   input  logic              start,
   input  logic [DDR_AW-1:0] base,
   input  logic [AW-1:0]     len,
   output logic              busy,
   output logic              done,
   input  logic              ddram_busy,
   output logic              ddram_rd,
   output logic [7:0]        ddram_burstcnt,
   output logic [DDR_AW-1:0] ddram_addr,
   input  logic [63:0]       ddram_dout,
   input  logic              ddram_dout_ready,
   output logic              ioctl_wr,
   output logic [AW-1:0]     ioctl_addr,
   output logic [OW-1:0]     ioctl_dout,
   input  logic              prog_we,
   input  logic              prog_rdy,
   input  logic              dwnld_busy
`ifdef JTFRAME_DWNLD_CKSUM_EN
   ,
   output logic [15:0]       cksum
`endif
);
   localparam int STEP = byte_step(OW);
   state_t            st, nx;
   logic [DDR_AW-1:0] base_r;
   logic [AW-1:0]     len_r, words_rd;
   logic [AW:0]       sent, rem, total_words, words_left;
   logic [7:0]        bcnt, burst_n, wcnt, rword;
   logic              wfirst, last_slice, adv, all_sent, buf_end;
   logic [OW-1:0]     slice;
   logic              unused_prog_we;
   assign unused_prog_we = prog_we;
   assign total_words = ({1'b0, len_r} + (AW+1)'(7)) >> 3;
   assign words_left  = total_words - {1'b0, words_rd};
   assign burst_n     = min_burst(32'(words_left), BURST);
   assign rem         = {1'b0, len_r} - sent;
   assign all_sent    = sent + (AW+1)'(STEP) >= {1'b0, len_r};
   assign buf_end     = last_slice && rword == bcnt - 8'd1;
   // dwnld_busy only matters on the first WAIT cycle; after that only prog_rdy releases us
   assign adv = st == ST_WAIT && (prog_rdy || (wfirst && !dwnld_busy));
   assign busy           = st != ST_IDLE && st != ST_FIN;
   assign done           = st == ST_FIN;
   assign ddram_rd       = st == ST_REQ && !ddram_busy;
   assign ddram_burstcnt = st == ST_REQ ? burst_n : 8'd0;
   assign ddram_addr     = st == ST_REQ ? base_r + DDR_AW'(words_rd) : '0;
   assign ioctl_wr       = st == ST_SER;
   assign ioctl_dout     = !ioctl_wr ? '0 : (OW > 8 && rem == (AW+1)'(1)) ? slice & OW'(8'hff) : slice;
   jtframe_ddr_romload_buf #(.OW(OW), .BURST(BURST)) u_buf (
      .rst        (rst),
      .clk        (clk),
      .clr        (st == ST_REQ),
      .we         (st == ST_FILL && ddram_dout_ready),
      .adv        (adv),
      .din        (ddram_dout),
      .wcnt       (wcnt),
      .rword      (rword),
      .last_slice (last_slice),
      .slice      (slice)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) st <= ST_IDLE;
      else     st <= nx;
   always_comb begin
      nx = st;
      unique case (st)
         ST_IDLE: if (start) nx = len != '0 ? ST_REQ : ST_FIN;
         ST_REQ:  if (!ddram_busy) nx = ST_FILL;
         ST_FILL: if (ddram_dout_ready && wcnt == bcnt - 8'd1) nx = ST_SER;
         ST_SER:  nx = ST_WAIT;
         ST_WAIT: if (adv) nx = all_sent ? ST_FIN : buf_end ? ST_REQ : ST_SER;
         ST_FIN:  nx = ST_IDLE;
         default: nx = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         base_r     <= '0;
         len_r      <= '0;
         words_rd   <= '0;
         sent       <= '0;
         ioctl_addr <= '0;
         bcnt       <= '0;
         wfirst     <= 1'b0;
      end else begin
         if (st == ST_IDLE && start) begin
            base_r     <= base;
            len_r      <= len;
            words_rd   <= '0;
            sent       <= '0;
            ioctl_addr <= '0;
         end
         if (ddram_rd) begin
            words_rd <= words_rd + AW'(burst_n);
            bcnt     <= burst_n;
         end
         wfirst <= st == ST_SER;
         if (adv) begin
            sent       <= sent + (AW+1)'(STEP);
            ioctl_addr <= ioctl_addr + AW'(STEP);
         end
      end
`ifdef JTFRAME_DWNLD_CKSUM_EN
   logic [15:0] bsum;
   always_comb begin
      bsum = '0;
      for (int i = 0; i < STEP; i++) bsum = bsum + 16'(ioctl_dout[i*8 +: 8]);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst)                         cksum <= '0;
      else if (st == ST_IDLE && start) cksum <= '0;
      else if (ioctl_wr)               cksum <= cksum + bsum;
`endif
endmodule

// File: tb/tb_jtframe_ddr_romload.sv
// tb_jtframe_ddr_romload: directed bench with DDR3 and programmer models, OW=8 and OW=16 loaders.
module tb_jtframe_ddr_romload;
   logic clk = 0, rst = 1, start8 = 0, start16 = 0;
   logic [28:0] base_in = '0;
   logic [26:0] len_in = '0;
   logic ddram_busy = 0, ddram_dout_ready = 0;
   logic [63:0] ddram_dout = '0;
   logic prog_we = 0, prog_rdy = 0, dwnld_busy = 0;
   logic busy8, done8, rd8, wr8, busy16, done16, rd16, wr16;
   logic [7:0] bcnt8, bcnt16, dout8;
   logic [28:0] daddr8, daddr16;
   logic [26:0] addr8, addr16;
   logic [15:0] dout16;
`ifdef JTFRAME_DWNLD_CKSUM_EN
   logic [15:0] cksum8, cksum16;
`endif
   jtframe_ddr_romload #(.OW(8)) u8 (
      .rst(rst), .clk(clk), .start(start8), .base(base_in), .len(len_in),
      .busy(busy8), .done(done8), .ddram_busy(ddram_busy), .ddram_rd(rd8),
      .ddram_burstcnt(bcnt8), .ddram_addr(daddr8), .ddram_dout(ddram_dout),
      .ddram_dout_ready(ddram_dout_ready), .ioctl_wr(wr8), .ioctl_addr(addr8),
      .ioctl_dout(dout8), .prog_we(prog_we), .prog_rdy(prog_rdy), .dwnld_busy(dwnld_busy)
`ifdef JTFRAME_DWNLD_CKSUM_EN
      , .cksum(cksum8)
`endif
   );
   jtframe_ddr_romload #(.OW(16)) u16 (
      .rst(rst), .clk(clk), .start(start16), .base(base_in), .len(len_in),
      .busy(busy16), .done(done16), .ddram_busy(ddram_busy), .ddram_rd(rd16),
      .ddram_burstcnt(bcnt16), .ddram_addr(daddr16), .ddram_dout(ddram_dout),
      .ddram_dout_ready(ddram_dout_ready), .ioctl_wr(wr16), .ioctl_addr(addr16),
      .ioctl_dout(dout16), .prog_we(prog_we), .prog_rdy(prog_rdy), .dwnld_busy(dwnld_busy)
`ifdef JTFRAME_DWNLD_CKSUM_EN
      , .cksum(cksum16)
`endif
   );
   always #5 clk = ~clk;
   logic sel16 = 0;
   logic [28:0] cur_base = '0;
   logic [26:0] cur_len = '0;
   int nw, nrd, ndone, nbusy, ngap2, wdone, done_cyc, first_rd, st_cyc, prev_wr;
   int cyc = 0, n_chk = 0, n_pass = 0;
   logic [26:0] last_addr;
   logic [15:0] last_dout;
   logic [7:0] last_bcnt;
   bit pmode = 0, extra = 0, ddr_active = 0;
   logic o_wr, o_rd, o_done, o_busy;
   logic [26:0] o_addr;
   logic [15:0] o_dout;
   logic [7:0] o_bcnt;
   logic [28:0] o_daddr;
   assign o_wr    = sel16 ? wr16 : wr8;
   assign o_rd    = sel16 ? rd16 : rd8;
   assign o_done  = sel16 ? done16 : done8;
   assign o_busy  = sel16 ? busy16 : busy8;
   assign o_addr  = sel16 ? addr16 : addr8;
   assign o_dout  = sel16 ? dout16 : {8'h00, dout8};
   assign o_bcnt  = sel16 ? bcnt16 : bcnt8;
   assign o_daddr = sel16 ? daddr16 : daddr8;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [7:0] ddr_byte(input longint k);
      return 8'(k % 255 + 1);
   endfunction
   function automatic logic [63:0] ddr_word(input logic [28:0] a);
      logic [63:0] w;
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = ddr_byte(longint'(a) * 8 + j);
      return w;
   endfunction
   function automatic logic [15:0] exp_dout(input int idx);
      int step;
      logic [15:0] v;
      step = sel16 ? 2 : 1;
      v = '0;
      for (int j = 0; j < step; j++)
         if (idx * step + j < int'(cur_len)) v[j*8 +: 8] = ddr_byte(longint'(cur_base) * 8 + idx * step + j);
      return v;
   endfunction
   // DDR3 model: answers each read after a random lag with consecutive words
   initial begin
      logic [28:0] a;
      int n, left;
      forever begin
         @(negedge clk);
         if (o_rd) begin
            ddr_active = 1;
            left = (int'(cur_len) + 7) / 8 - wdone;
            check("rd_while_busy", ddram_busy, 0);
            check("burstcnt", o_bcnt, left < 32 ? left : 32);
            check("ddram_addr", o_daddr, cur_base + 29'(wdone));
            if (nrd == 0) first_rd = cyc;
            nrd++;
            last_bcnt = o_bcnt;
            a = o_daddr;
            n = int'(o_bcnt) + (extra ? 1 : 0);
            wdone += int'(o_bcnt);
            @(posedge clk);
            repeat ($urandom_range(0, 7)) @(posedge clk);
            for (int k = 0; k < n; k++) begin
               #1 ddram_dout = ddr_word(a + 29'(k));
               ddram_dout_ready = 1;
               @(posedge clk);
            end
            #1 ddram_dout_ready = 0;
            ddr_active = 0;
         end
      end
   end
   // programmer model: in pmode, accepts each write and completes it after 0..2 cycles
   initial begin
      forever begin
         @(negedge clk);
         if (o_wr && pmode) begin
            @(posedge clk);
            #1 dwnld_busy = 1;
            prog_we = 1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 prog_rdy = 1;
            @(posedge clk);
            #1 prog_rdy = 0;
            dwnld_busy = 0;
            prog_we = 0;
         end
      end
   end
   always @(negedge clk) begin
      if (o_wr) begin
         check("wr_addr", o_addr, nw * (sel16 ? 2 : 1));
         check("wr_data", o_dout, exp_dout(nw));
         if (nw > 0 && cyc - prev_wr == 2) ngap2++;
         prev_wr = cyc;
         last_addr = o_addr;
         last_dout = o_dout;
         nw++;
      end
      if (o_done) begin
         ndone++;
         done_cyc = cyc;
      end
      if (o_busy) nbusy++;
   end
   task automatic kick(input bit w16, input logic [28:0] b, input logic [26:0] l);
      sel16 = w16; cur_base = b; cur_len = l;
      nw = 0; nrd = 0; ndone = 0; nbusy = 0; ngap2 = 0; wdone = 0; first_rd = -1; done_cyc = -1;
      @(posedge clk);
      #1 st_cyc = cyc;
      base_in = b; len_in = l; start8 = !w16; start16 = w16;
      @(posedge clk);
      #1 start8 = 0; start16 = 0;
   endtask
   task automatic run(input bit w16, input logic [28:0] b, input logic [26:0] l, input int maxc);
      kick(w16, b, l);
      for (int c = 0; c < maxc && ndone == 0; c++) @(posedge clk);
      repeat (3) @(posedge clk);
      check("one_done", ndone, 1);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check("rst_outs", |{busy8, done8, rd8, bcnt8, daddr8, wr8, addr8, dout8}, 0);
      #1 rst = 0;
      @(negedge clk);
      check("idle_outs", |{busy16, done16, rd16, bcnt16, daddr16, wr16, addr16, dout16}, 0);
      run(0, 29'd4, 27'd0, 20);
      check("len0_done_lat", done_cyc - st_cyc, 1);
      check("len0_rd", nrd, 0);
      check("len0_busy", nbusy, 0);
      extra = 1;
      run(0, 29'd0, 27'd1000, 8000);
      extra = 0;
      check("t2_rd", nrd, 4);
      check("t2_lastbcnt", last_bcnt, 29);
      check("t2_nw", nw, 1000);
      check("t2_lastaddr", last_addr, 999);
      check("t2_rd_lat", first_rd - st_cyc, 1);
      pmode = 1;
      run(0, 29'd3, 27'd4096, 40000);
      check("t1_rd", nrd, 16);
      check("t1_nw", nw, 4096);
      check("t1_lastaddr", last_addr, 4095);
      run(1, 29'd2, 27'd7, 300);
      check("t3_nw", nw, 4);
      check("t3_lastaddr", last_addr, 6);
      check("t3_hi_byte", last_dout[15:8], 0);
      pmode = 0;
      run(0, 29'd0, 27'd64, 2000);
      check("t4_gap2", ngap2, 63);
      check("t4_nw", nw, 64);
      ddram_busy = 1;
      fork
         run(0, 29'd7, 27'd16, 2000);
         begin
            repeat (22) @(posedge clk);
            #1 ddram_busy = 0;
         end
      join
      check("t4_rd_stall", first_rd - st_cyc, 21);
      check("t4_stall_nw", nw, 16);
      kick(0, 29'd0, 27'd256);
      for (int c = 0; c < 50 && nrd == 0; c++) @(posedge clk);
      check("t5_rd_seen", nrd, 1);
      @(posedge clk);
      #1 rst = 1;
      @(negedge clk);
      check("t5_rst_outs", |{busy8, done8, rd8, bcnt8, daddr8, wr8, addr8, dout8}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      for (int c = 0; c < 200 && ddr_active; c++) @(posedge clk);
      check("t5_ddr_idle", ddr_active, 0);
      run(0, 29'd0, 27'd16, 500);
      check("t5_restart_nw", nw, 16);
      check("t5_restart_last", last_addr, 15);
`ifdef JTFRAME_DWNLD_CKSUM_EN
      begin
         logic [15:0] sum;
         sum = '0;
         for (int i = 0; i < 510; i++) sum = sum + 16'(ddr_byte(i));
         run(0, 29'd0, 27'd510, 4000);
         check("t6_cksum", cksum8, sum);
      end
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
